// File: rtl/fetch_unit_pkg.sv
// Shared types and helpers for the instruction-fetch front end.
package definitions;

  typedef enum logic {
    FETCH_IDLE = 1'b0,
    FETCH_RUN  = 1'b1
  } fetch_state_t;

  localparam int DEFAULT_INSTRUCTION_WIDTH = 32;
  localparam int DEFAULT_ADDR_WIDTH        = 32;
  localparam int DEFAULT_QUEUE_DEPTH       = 4;

  // Counters must be able to hold the value QUEUE_DEPTH itself.
  function automatic int counterWidth(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-unit bus: IRAM request/response channel, decode handshake and redirect.
interface fetch_unit_if #(
  parameter int ADDR_WIDTH        = 32,
  parameter int INSTRUCTION_WIDTH = 32
);
  // Valid/ready rule: a transfer happens in exactly the cycles where both
  // imemReq&&imemGnt (request) or instrValid&&instrReady (decode) are high;
  // the sender holds its payload stable until then, and valid never waits on ready.
  logic                         imemReq;
  logic [ADDR_WIDTH-1:0]        imemAddr;
  logic                         imemGnt;
  logic                         imemRValid;
  logic [INSTRUCTION_WIDTH-1:0] imemRData;
  logic                         redirect;
  logic [ADDR_WIDTH-1:0]        redirectAddr;
  logic                         instrValid;
  logic                         instrReady;
  logic [INSTRUCTION_WIDTH-1:0] instrOut;
  logic [ADDR_WIDTH-1:0]        pcOut;

  modport master (
    output imemReq, imemAddr, instrValid, instrOut, pcOut,
    input  imemGnt, imemRValid, imemRData, redirect, redirectAddr, instrReady
  );

  modport slave (
    input  imemReq, imemAddr, instrValid, instrOut, pcOut,
    output imemGnt, imemRValid, imemRData, redirect, redirectAddr, instrReady
  );
endinterface

// File: rtl/fetch_unit_queue.sv
// Synchronous FIFO of {pc, instr} entries; the head holds its last value while empty.
module fetch_queue import definitions::*; #(
  parameter int QUEUE_DEPTH = DEFAULT_QUEUE_DEPTH,
  parameter int ENTRY_WIDTH = 64
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  push,
  input  logic                                  pop,
  input  logic                                  flush,
  input  logic [ENTRY_WIDTH-1:0]                pushData,
  output logic [ENTRY_WIDTH-1:0]                headData,
  output logic [counterWidth(QUEUE_DEPTH)-1:0]  count,
  output logic                                  empty
);
  localparam int PtrW = $clog2(QUEUE_DEPTH);
  localparam int CntW = counterWidth(QUEUE_DEPTH);

  logic [ENTRY_WIDTH-1:0] mem [QUEUE_DEPTH];
  logic [PtrW-1:0]        rdPtr;
  logic [PtrW-1:0]        wrPtr;
  logic [ENTRY_WIDTH-1:0] lastHead;
  logic                   doPop;
  logic                   doPush;

  assign empty    = (count == '0);
  assign doPop    = pop && !empty;
  assign doPush   = push && ((count != CntW'(QUEUE_DEPTH)) || doPop);
  assign headData = empty ? lastHead : mem[rdPtr];

  always_ff @(posedge clk) begin
    if (rst) begin
      rdPtr    <= '0;
      wrPtr    <= '0;
      count    <= '0;
      lastHead <= '0;
    end else begin
      // Track what is being shown so an emptied queue keeps presenting it.
      if (!empty) lastHead <= mem[rdPtr];
      if (flush) begin
        rdPtr <= '0;
        wrPtr <= '0;
        count <= '0;
      end else begin
        if (doPush) wrPtr <= wrPtr + PtrW'(1);
        if (doPop)  rdPtr <= rdPtr + PtrW'(1);
        count <= count + CntW'(doPush) - CntW'(doPop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (doPush && !flush) mem[wrPtr] <= pushData;
  end

endmodule

// File: rtl/fetch_unit.sv
// Decoupled instruction fetch: pipelined IRAM requests, credit-limited queue, redirect flush.
module fetch_unit import definitions::*; #(
  parameter int                    INSTRUCTION_WIDTH = DEFAULT_INSTRUCTION_WIDTH,
  parameter int                    ADDR_WIDTH        = DEFAULT_ADDR_WIDTH,
  parameter int                    QUEUE_DEPTH       = DEFAULT_QUEUE_DEPTH,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC          = '0
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  startProcess,
  input  logic                                  halt,
  fetch_unit_if.master                          bus,
  output fetch_state_t                          dbgState,
  output logic [counterWidth(QUEUE_DEPTH)-1:0]  dbgCount,
  output logic [counterWidth(QUEUE_DEPTH)-1:0]  dbgOutstanding
);
  localparam int CntW = counterWidth(QUEUE_DEPTH);

  fetch_state_t          state;
  fetch_state_t          stateNext;
  logic [ADDR_WIDTH-1:0] fetchPc;
  logic [ADDR_WIDTH-1:0] respPc;
  logic [ADDR_WIDTH-1:0] redirectPc;
  logic [CntW-1:0]       outstanding;
  logic [CntW-1:0]       dropCount;
  logic [CntW-1:0]       count;
  logic [CntW:0]         inUse;
  logic                  queueEmpty;
  logic                  grant;
  logic                  respKeep;
  logic                  pop;
  logic [ADDR_WIDTH+INSTRUCTION_WIDTH-1:0] headEntry;

  always_ff @(posedge clk) begin
    if (rst) state <= FETCH_IDLE;
    else     state <= stateNext;
  end

  // Credit check uses only registered counters, so instrReady never reaches imemReq.
  always_comb begin
    stateNext   = state;
    bus.imemReq = 1'b0;
    case (state)
      FETCH_IDLE: if (startProcess) stateNext = FETCH_RUN;
      FETCH_RUN:  bus.imemReq = !halt && !bus.redirect
                                && (inUse < (CntW+1)'(QUEUE_DEPTH));
      default:    stateNext = FETCH_IDLE;
    endcase
  end

  assign inUse      = {1'b0, count} + {1'b0, outstanding};
  assign grant      = bus.imemReq && bus.imemGnt;
  assign redirectPc = {bus.redirectAddr[ADDR_WIDTH-1:2], 2'b00};
  assign respKeep   = bus.imemRValid && (dropCount == '0) && !bus.redirect;
  assign pop        = bus.instrValid && bus.instrReady && !bus.redirect;

  always_ff @(posedge clk) begin
    if (rst) begin
      fetchPc     <= RESET_PC;
      respPc      <= RESET_PC;
      outstanding <= '0;
      dropCount   <= '0;
    end else begin
      outstanding <= outstanding + CntW'(grant) - CntW'(bus.imemRValid);
      if (bus.redirect) begin
        fetchPc   <= redirectPc;
        respPc    <= redirectPc;
        // A response landing in the redirect cycle is discarded right now.
        dropCount <= outstanding - CntW'(bus.imemRValid);
      end else begin
        if (grant) fetchPc <= fetchPc + ADDR_WIDTH'(4);
        if (respKeep)             respPc    <= respPc + ADDR_WIDTH'(4);
        else if (bus.imemRValid)  dropCount <= dropCount - CntW'(1);
      end
    end
  end

  fetch_queue #(
    .QUEUE_DEPTH(QUEUE_DEPTH),
    .ENTRY_WIDTH(ADDR_WIDTH + INSTRUCTION_WIDTH)
  ) queue (
    .clk      (clk),
    .rst      (rst),
    .push     (respKeep),
    .pop      (pop),
    .flush    (bus.redirect),
    .pushData ({respPc, bus.imemRData}),
    .headData (headEntry),
    .count    (count),
    .empty    (queueEmpty)
  );

  assign bus.imemAddr              = fetchPc;
  assign bus.instrValid            = !queueEmpty;
  assign {bus.pcOut, bus.instrOut} = headEntry;

  assign dbgState       = state;
  assign dbgCount       = count;
  assign dbgOutstanding = outstanding;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: in-order variable-latency IRAM model plus a program-order PC scoreboard.
module tb_fetch_unit;
  import definitions::*;

  localparam int              AW       = 32;
  localparam int              IW       = 32;
  localparam int              DEPTH    = 4;
  localparam logic [AW-1:0]   RESET_PC = 32'h0;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         startProcess;
  logic         halt;
  fetch_state_t dbgState;
  logic [$clog2(DEPTH+1)-1:0] dbgCount;
  logic [$clog2(DEPTH+1)-1:0] dbgOutstanding;

  fetch_unit_if #(.ADDR_WIDTH(AW), .INSTRUCTION_WIDTH(IW)) bus ();

  fetch_unit #(
    .INSTRUCTION_WIDTH(IW), .ADDR_WIDTH(AW), .QUEUE_DEPTH(DEPTH), .RESET_PC(RESET_PC)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .startProcess   (startProcess),
    .halt           (halt),
    .bus            (bus),
    .dbgState       (dbgState),
    .dbgCount       (dbgCount),
    .dbgOutstanding (dbgOutstanding)
  );

  always #5 clk = ~clk;

  int nChecks = 0;
  int nPass   = 0;
  int nFail   = 0;
  int cyc     = 0;
  int latency = 1;
  int gntPct  = 100;
  int rdyPct  = 100;
  int lastDue = 0;
  int popCount = 0;
  bit doReset = 1'b1;
  bit haltIn  = 1'b0;

  logic [AW-1:0] pendAddr[$];
  int            pendDue[$];
  logic [AW-1:0] exp_q[$];

  function automatic logic [IW-1:0] instrOf(input logic [AW-1:0] a);
    return a ^ 32'hC0DE_5A5A;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    nChecks++;
    assert (obs === expv) nPass++;
    else begin
      nFail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Program order restarts at pc and continues in +4 steps.
  task automatic restartExp(input logic [AW-1:0] pc);
    exp_q.delete();
    for (int i = 0; i < 8; i++) exp_q.push_back(pc + 32'(4 * i));
  endtask

  // One clock cycle: drive at the falling edge, observe just after, then model IRAM and decode.
  task automatic cycle(input bit start, input bit redir, input logic [AW-1:0] raddr);
    int            due;
    logic [AW-1:0] expPc;
    @(negedge clk);
    cyc++;
    rst              = doReset;
    halt             = haltIn;
    startProcess     = start;
    bus.redirect     = redir;
    bus.redirectAddr = raddr;
    bus.imemGnt      = ($urandom_range(99) < gntPct);
    bus.instrReady   = ($urandom_range(99) < rdyPct);
    if (!doReset && pendDue.size() > 0 && pendDue[0] <= cyc) begin
      bus.imemRValid = 1'b1;
      bus.imemRData  = instrOf(pendAddr[0]);
    end else begin
      bus.imemRValid = 1'b0;
      bus.imemRData  = $urandom();
    end
    #1;
    if (doReset) begin
      pendAddr.delete();
      pendDue.delete();
      lastDue = 0;
    end else begin
      if (halt || redir) check("req_masked", 32'(bus.imemReq), 32'd0);
      if (bus.imemRValid) begin
        void'(pendAddr.pop_front());
        void'(pendDue.pop_front());
      end
      if (bus.imemReq && bus.imemGnt) begin
        due = cyc + latency;
        if (due <= lastDue) due = lastDue + 1;
        pendAddr.push_back(bus.imemAddr);
        pendDue.push_back(due);
        lastDue = due;
        check("credit_limit", 32'(pendAddr.size() <= DEPTH), 32'd1);
      end
      if (bus.instrValid && bus.instrReady && !redir) begin
        popCount++;
        if (exp_q.size() == 0) check("pop_unexpected", 32'd1, 32'd0);
        else begin
          expPc = exp_q.pop_front();
          exp_q.push_back(exp_q[$] + 32'd4);
          check("pop_pc", bus.pcOut, expPc);
          check("pop_instr", bus.instrOut, instrOf(expPc));
        end
      end
      if (redir) restartExp({raddr[AW-1:2], 2'b00});
    end
  endtask

  task automatic step();
    cycle(1'b0, 1'b0, '0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit            found;
    int            redirCyc;
    int            p0;
    startProcess = 1'b0;
    halt = 1'b0;
    bus.imemGnt = 1'b0;
    bus.imemRValid = 1'b0;
    bus.imemRData = '0;
    bus.redirect = 1'b0;
    bus.redirectAddr = '0;
    bus.instrReady = 1'b0;

    // Reset values
    repeat (3) step();
    doReset = 1'b0;
    step();
    check("rst_req", 32'(bus.imemReq), 32'd0);
    check("rst_addr", bus.imemAddr, RESET_PC);
    check("rst_valid", 32'(bus.instrValid), 32'd0);
    check("rst_instr", bus.instrOut, 32'd0);
    check("rst_pc", bus.pcOut, 32'd0);
    check("rst_state", 32'(dbgState), 32'(FETCH_IDLE));
    check("rst_count", 32'(dbgCount), 32'd0);
    check("rst_outstanding", 32'(dbgOutstanding), 32'd0);
    step();
    check("idle_req", 32'(bus.imemReq), 32'd0);

    // Zero-wait stream
    restartExp(RESET_PC);
    cycle(1'b1, 1'b0, '0);
    check("start_req", 32'(bus.imemReq), 32'd0);
    step();
    check("first_req", 32'(bus.imemReq), 32'd1);
    check("first_addr", bus.imemAddr, RESET_PC);
    check("run_state", 32'(dbgState), 32'(FETCH_RUN));
    step();
    check("first_lat_valid", 32'(bus.instrValid), 32'd0);
    step();
    check("first_visible", 32'(bus.instrValid), 32'd1);
    check("first_pc", bus.pcOut, RESET_PC);
    repeat (12) begin
      step();
      check("stream_valid", 32'(bus.instrValid), 32'd1);
    end

    // Backpressure
    rdyPct = 0;
    repeat (10) step();
    check("bp_count", 32'(dbgCount), 32'd4);
    check("bp_req", 32'(bus.imemReq), 32'd0);
    check("bp_credit", 32'(dbgCount) + 32'(dbgOutstanding), 32'd4);
    rdyPct = 100;
    repeat (12) step();

    // Redirect with 3 outstanding on a 3-cycle IRAM
    latency = 3;
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      step();
      if (pendAddr.size() == 3) found = 1'b1;
    end
    check("rd3_reach", 32'(found), 32'd1);
    cycle(1'b0, 1'b1, 32'h0000_0103);
    redirCyc = cyc;
    step();
    check("rd3_req", 32'(bus.imemReq), 32'd1);
    check("rd3_addr", bus.imemAddr, 32'h0000_0100);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      if (bus.instrValid) found = 1'b1;
    end
    check("rd3_valid", 32'(found), 32'd1);
    check("rd3_first_pc", bus.pcOut, 32'h0000_0100);
    check("rd3_latency", 32'(cyc - redirCyc), 32'd5);

    // Redirect coinciding with a response and a pop
    latency = 1;
    repeat (8) step();
    cycle(1'b0, 1'b1, 32'h0000_0200);
    step();
    check("rr_empty", 32'(bus.instrValid), 32'd0);
    check("rr_addr", bus.imemAddr, 32'h0000_0200);
    step();
    check("rr_wait", 32'(bus.instrValid), 32'd0);
    step();
    check("rr_valid", 32'(bus.instrValid), 32'd1);
    check("rr_pc", bus.pcOut, 32'h0000_0200);

    // PC wrap through redirect target
    cycle(1'b0, 1'b1, 32'hFFFF_FFFB);
    step();
    check("wrap_req0", 32'(bus.imemReq), 32'd1);
    check("wrap_addr0", bus.imemAddr, 32'hFFFF_FFF8);
    step();
    check("wrap_addr1", bus.imemAddr, 32'hFFFF_FFFC);
    step();
    check("wrap_req2", 32'(bus.imemReq), 32'd1);
    check("wrap_addr2", bus.imemAddr, 32'h0000_0000);
    repeat (6) step();

    // Halt drains without new requests
    p0 = popCount;
    haltIn = 1'b1;
    repeat (8) step();
    check("halt_count", 32'(dbgCount), 32'd0);
    check("halt_outstanding", 32'(dbgOutstanding), 32'd0);
    check("halt_valid", 32'(bus.instrValid), 32'd0);
    check("halt_drained", 32'(popCount > p0), 32'd1);
    check("halt_state", 32'(dbgState), 32'(FETCH_RUN));
    haltIn = 1'b0;
    repeat (4) step();

    // Randomized traffic
    p0 = popCount;
    gntPct = 70;
    rdyPct = 60;
    for (int i = 0; i < 1500; i++) begin
      latency = $urandom_range(1, 4);
      if ($urandom_range(99) < 5) haltIn = !haltIn;
      if ($urandom_range(99) < 3) cycle(1'b0, 1'b1, $urandom());
      else step();
    end
    haltIn = 1'b0;
    check("rand_progress", 32'(popCount - p0 > 100), 32'd1);

    // Reset in the middle of a burst
    latency = 1;
    gntPct = 100;
    rdyPct = 100;
    repeat (8) step();
    doReset = 1'b1;
    step();
    doReset = 1'b0;
    step();
    check("mrst_req", 32'(bus.imemReq), 32'd0);
    check("mrst_valid", 32'(bus.instrValid), 32'd0);
    check("mrst_addr", bus.imemAddr, RESET_PC);
    check("mrst_state", 32'(dbgState), 32'(FETCH_IDLE));
    repeat (3) step();
    check("mrst_wait", 32'(bus.imemReq), 32'd0);
    restartExp(RESET_PC);
    cycle(1'b1, 1'b0, '0);
    repeat (6) step();
    check("restart_valid", 32'(bus.instrValid), 32'd1);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
